mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//   Responder end of the pipeline memory-request handshake (mem_re/mem_we, mem_addr, mem_busy,
//   mem_done, mem_data). Serves one word request at a time from the fetch or data stage against
//   a byte-wide synchronous RAM, sequencing four byte accesses per 32-bit word (little-endian).
//   Sits between the pipeline stages and the byte RAM.
// PARAMETERS
//   ADDR_W  32  width of request address (`MemAddrBus)
//   RAM_AW  17  byte-address width of attached RAM; request address bits above RAM_AW-1 ignored
// PORTS
//   clk         in   1       clock, all state updates on rising edge
//   rst_n       in   1       asynchronous reset, active low
//   mem_re      in   1       read request (word)
//   mem_we      in   1       write request (word, byte-masked)
//   mem_addr_i  in   ADDR_W  request byte address; bits [1:0] ignored (word aligned)
//   mem_data_i  in   32      write data, byte k = bits [8k+7:8k]
//   mem_sel_i   in   4       write byte enables, bit k -> byte k
//   mem_data_o  out  32      read data, valid while mem_done=1, held until next read completes
//   mem_busy    out  1       request in progress; requests ignored while high
//   mem_done    out  1       one-cycle completion pulse
//   ram_addr    out  RAM_AW  byte address to RAM
//   ram_we      out  1       RAM byte write enable
//   ram_wdata   out  8       RAM write byte
//   ram_rdata   in   8       RAM read byte, valid one cycle after ram_addr presented
// BEHAVIOUR
//   - Reset (rst_n=0, async): state IDLE; mem_data_o=0, mem_busy=0, mem_done=0, ram_addr=0,
//     ram_we=0, ram_wdata=0, byte counter=0. Reset mid-request aborts it: no done, no further
//     RAM writes (ram_we drops immediately, not at next edge).
//   - States: IDLE, READ, WRITE, DONE.
//   - Accept: on edge where state is IDLE or DONE and (mem_re|mem_we)=1. Base address
//     latched = {mem_addr_i[RAM_AW-1:2],2'b00}; write data/sel latched at accept, later changes
//     on inputs ignored. mem_we and mem_re both high -> write served, read dropped.
//   - Cycle numbering: cycle 1 = first cycle after accept edge.
//   - READ: cycles 1-4 drive ram_addr=base+k (k=0..3), ram_we=0; byte k captured from ram_rdata
//     at end of cycle k+2 into bits [8k+7:8k]; mem_busy=1 cycles 1-5; cycle 6 = DONE:
//     mem_done=1, mem_busy=0, mem_data_o = assembled word. Read latency 6 cycles.
//   - WRITE: cycles 1-4 drive ram_addr=base+k, ram_wdata=byte k, ram_we=sel[k]; mem_busy=1
//     cycles 1-4; cycle 5 = DONE: mem_done=1, mem_busy=0; mem_data_o unchanged. sel=0000 still
//     takes 5 cycles with no RAM write.
//   - DONE lasts one cycle; returns to IDLE unless a new request is accepted at its end
//     (back-to-back allowed, mem_done never high two consecutive cycles for one request).
//   - ram_addr holds last value when IDLE/DONE; ram_we=0 outside WRITE.
//   - base+3 never carries across word boundary (aligned); top word of RAM needs no wrap logic.
//   - mem_busy is never high in the same cycle as mem_done; mem_busy=0 in IDLE.
// TESTING
//   - RAM bytes 0x100..0x103 = 11,22,33,44; mem_re, addr=0x102 -> ram_addr 0x100..0x103 in
//     cycles 1-4, cycle 6 mem_done=1, mem_data_o=0x44332211, busy high exactly cycles 1-5.
//   - mem_we addr=0x200 data=0xAABBCCDD sel=0101 -> ram_we only cycles 1,3 with DD,BB; readback
//     gives bytes 1,3 unchanged; done in cycle 5.
//   - Re-assert mem_re in DONE cycle of previous read -> second read accepted immediately,
//     next mem_done exactly 6 cycles later, no gap cycle.
//   - mem_re and mem_we both high -> write performed, no read done; toggle mem_addr_i/data
//     while busy -> no effect on addresses or written bytes.
//   - Assert rst_n=0 during write cycle 2 -> ram_we falls asynchronously, byte 2/3 not written,
//     no mem_done; after release, all outputs at reset values, new read completes normally.

Source files
------------

// File: rtl/mem_ctrl.sv
// Word-request responder for the pipeline memory handshake: serves one 32-bit
// read or byte-masked write at a time as four little-endian byte RAM accesses.
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int RAM_AW = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_data_i,
  input  logic [3:0]        mem_sel_i,
  output logic [31:0]       mem_data_o,
  output logic              mem_busy,
  output logic              mem_done,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state_reg;
  logic [2:0]        cnt_reg;
  logic [RAM_AW-3:0] word_reg;
  logic [23:0]       wr_data_reg;
  logic [2:0]        wr_sel_reg;
  logic [23:0]       rd_buf_reg;
  logic [1:0]        next_byte;
  logic              accept;
  logic              unused_addr_bits;

  assign accept    = ((state_reg == IDLE) || (state_reg == DONE)) && (mem_re || mem_we);
  assign next_byte = cnt_reg[1:0] + 2'd1;
  assign mem_busy  = (state_reg == READ) || (state_reg == WRITE);
  assign mem_done  = (state_reg == DONE);
  assign unused_addr_bits = ^{mem_addr_i[ADDR_W-1:RAM_AW], mem_addr_i[1:0]};

  // ram_we is a register under async reset, so reset removes it without waiting for an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= 3'd0;
      word_reg    <= '0;
      wr_data_reg <= 24'h0;
      wr_sel_reg  <= 3'b000;
      rd_buf_reg  <= 24'h0;
      mem_data_o  <= 32'h0;
      ram_addr    <= '0;
      ram_we      <= 1'b0;
      ram_wdata   <= 8'h00;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            word_reg <= mem_addr_i[RAM_AW-1:2];
            cnt_reg  <= 3'd0;
            ram_addr <= {mem_addr_i[RAM_AW-1:2], 2'b00};
            if (mem_we) begin
              state_reg   <= WRITE;
              ram_we      <= mem_sel_i[0];
              ram_wdata   <= mem_data_i[7:0];
              wr_data_reg <= mem_data_i[31:8];
              wr_sel_reg  <= mem_sel_i[3:1];
            end else begin
              state_reg <= READ;
            end
          end else begin
            state_reg <= IDLE;
          end
        end

        READ: begin
          cnt_reg <= cnt_reg + 3'd1;
          if (cnt_reg < 3'd3) begin
            ram_addr <= {word_reg, next_byte};
          end
          // RAM data trails the address by one cycle; bytes shift in from the top.
          if (cnt_reg == 3'd4) begin
            mem_data_o <= {ram_rdata, rd_buf_reg};
            state_reg  <= DONE;
          end else if (cnt_reg != 3'd0) begin
            rd_buf_reg <= {ram_rdata, rd_buf_reg[23:8]};
          end
        end

        WRITE: begin
          if (cnt_reg == 3'd3) begin
            state_reg <= DONE;
            ram_we    <= 1'b0;
          end else begin
            cnt_reg     <= cnt_reg + 3'd1;
            ram_addr    <= {word_reg, next_byte};
            ram_we      <= wr_sel_reg[0];
            ram_wdata   <= wr_data_reg[7:0];
            wr_data_reg <= {8'h00, wr_data_reg[23:8]};
            wr_sel_reg  <= {1'b0, wr_sel_reg[2:1]};
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural byte RAM (synchronous read, one-cycle latency).
module tb_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_o;
  logic        mem_busy;
  logic        mem_done;
  logic [16:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  logic [7:0]  ram [0:131071];
  logic        pre_we;
  logic [16:0] pre_addr;
  logic [7:0]  pre_data;

  int checks;
  int failures;

  mem_ctrl #(.ADDR_W(32), .RAM_AW(17)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_addr_i (mem_addr_i),
    .mem_data_i (mem_data_i),
    .mem_sel_i  (mem_sel_i),
    .mem_data_o (mem_data_o),
    .mem_busy   (mem_busy),
    .mem_done   (mem_done),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance to the falling edge of the next cycle.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic preload(input logic [16:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      pre_we   = 1'b1;
      pre_addr = a + 17'(i);
      pre_data = w[8*i +: 8];
      tick();
    end
    pre_we = 1'b0;
  endtask

  // Issue a read at the current negedge and check every cycle through done.
  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_word, input string tag);
    logic [16:0] base;
    base       = {addr[16:2], 2'b00};
    mem_re     = 1'b1;
    mem_addr_i = addr;
    tick();
    mem_re = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k <= 4) chk({tag, "_addr"}, 32'(ram_addr), 32'(base + 17'(k - 1)));
      chk({tag, "_busy"}, 32'(mem_busy), (k <= 5) ? 32'd1 : 32'd0);
      chk({tag, "_done"}, 32'(mem_done), (k == 6) ? 32'd1 : 32'd0);
      if (k == 6) chk({tag, "_data"}, mem_data_o, exp_word);
      else tick();
    end
  endtask

  initial begin
    logic [7:0] exp_b [0:3];
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    mem_re = 1'b0;
    mem_we = 1'b0;
    mem_addr_i = 32'h0;
    mem_data_i = 32'h0;
    mem_sel_i = 4'h0;
    pre_we = 1'b0;
    pre_addr = '0;
    pre_data = 8'h00;
    tick();
    chk("rst_data", mem_data_o, 32'h0);
    chk("rst_busy", 32'(mem_busy), 32'd0);
    chk("rst_done", 32'(mem_done), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    rst_n = 1'b1;

    preload(17'h100, 32'h44332211);
    preload(17'h200, 32'h04030201);
    preload(17'h300, 32'h00000000);
    preload(17'h500, 32'h00000000);
    tick();

    // Basic read, unaligned request address.
    do_read(32'h0000_0102, 32'h44332211, "rd1");
    tick();

    // Masked write 0101 to 0x200.
    mem_we = 1'b1;
    mem_addr_i = 32'h200;
    mem_data_i = 32'hAABBCCDD;
    mem_sel_i = 4'b0101;
    tick();
    mem_we = 1'b0;
    exp_b[0] = 8'hDD; exp_b[1] = 8'hCC; exp_b[2] = 8'hBB; exp_b[3] = 8'hAA;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) begin
        chk("wr_addr", 32'(ram_addr), 32'h200 + 32'(k - 1));
        chk("wr_we", 32'(ram_we), (k == 1 || k == 3) ? 32'd1 : 32'd0);
        if (k == 1 || k == 3) chk("wr_wdata", 32'(ram_wdata), 32'(exp_b[k-1]));
      end
      chk("wr_busy", 32'(mem_busy), (k <= 4) ? 32'd1 : 32'd0);
      chk("wr_done", 32'(mem_done), (k == 5) ? 32'd1 : 32'd0);
      if (k == 5) chk("wr_data_hold", mem_data_o, 32'h44332211);
      else tick();
    end
    tick();

    // Back-to-back: second read accepted in the DONE cycle of the first.
    do_read(32'h100, 32'h44332211, "b2b1");
    do_read(32'h200, 32'h04BB02DD, "b2b2");
    tick();

    // Both re and we: write wins; input changes while busy are ignored.
    mem_re = 1'b1;
    mem_we = 1'b1;
    mem_addr_i = 32'h300;
    mem_data_i = 32'h12345678;
    mem_sel_i = 4'b1111;
    tick();
    mem_re = 1'b0;
    mem_we = 1'b0;
    mem_addr_i = 32'h400;
    mem_data_i = 32'h0;
    mem_sel_i = 4'b0000;
    exp_b[0] = 8'h78; exp_b[1] = 8'h56; exp_b[2] = 8'h34; exp_b[3] = 8'h12;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) begin
        chk("rw_addr", 32'(ram_addr), 32'h300 + 32'(k - 1));
        chk("rw_we", 32'(ram_we), 32'd1);
        chk("rw_wdata", 32'(ram_wdata), 32'(exp_b[k-1]));
        mem_addr_i = 32'h400 + 32'(4 * k);
        mem_data_i = ~mem_data_i;
      end
      chk("rw_done", 32'(mem_done), (k == 5) ? 32'd1 : 32'd0);
      if (k == 5) chk("rw_data_hold", mem_data_o, 32'h04BB02DD);
      else tick();
    end
    tick();
    chk("rw_idle_done", 32'(mem_done), 32'd0);
    do_read(32'h300, 32'h12345678, "rwrd");
    tick();

    // Reset during write cycle 2.
    mem_we = 1'b1;
    mem_addr_i = 32'h500;
    mem_data_i = 32'hCAFEBABE;
    mem_sel_i = 4'b1111;
    tick();
    mem_we = 1'b0;
    chk("ab_we_c1", 32'(ram_we), 32'd1);
    tick();
    chk("ab_we_c2", 32'(ram_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ab_we_async", 32'(ram_we), 32'd0);
    chk("ab_busy_async", 32'(mem_busy), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("ab_no_done", 32'(mem_done), 32'd0);
    end
    chk("ab_rst_data", mem_data_o, 32'h0);
    chk("ab_rst_addr", 32'(ram_addr), 32'd0);
    chk("ab_rst_wdata", 32'(ram_wdata), 32'd0);
    chk("ab_byte0", 32'(ram[17'h500]), 32'hBE);
    chk("ab_byte2", 32'(ram[17'h502]), 32'h00);
    chk("ab_byte3", 32'(ram[17'h503]), 32'h00);
    rst_n = 1'b1;
    tick();
    chk("ab_post_busy", 32'(mem_busy), 32'd0);
    do_read(32'h100, 32'h44332211, "post");
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
